idex_pipeline_register: RTL and testbench

//   ID/EX pipeline register. Closes the load-use stall loop: it drives MemReadFromIDEX and
//   EX_Instruction to the hazard detection unit and consumes that unit's WriteEnableMuxControl
//   to insert a bubble. Also applies branch flushes (deferred while the pipeline is held)
//   and counts inserted bubbles for performance reporting.

---
 rtl/pipeline_pkg.sv | 27 ++
 rtl/sat_counter.sv | 33 +++
 rtl/idex_pipeline_register.sv | 109 ++++++++++
 tb/tb_idex_pipeline_register.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_pkg
// Description : Shared pipeline definitions: packed control word layout and
//               the canonical no-op instruction encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package pipeline_pkg;

    // Width of the packed control word carried down the pipeline
    localparam int CTRL_WIDTH = 10;

    // Control word bit map
    localparam int CTL_REGWRITE  = 0;
    localparam int CTL_MEMREAD   = 1;
    localparam int CTL_MEMWRITE  = 2;
    localparam int CTL_MEMTOREG  = 3;
    localparam int CTL_ALUSRC    = 4;
    localparam int CTL_REGDST    = 5;
    localparam int CTL_ALUOP_LSB = 6;
    localparam int CTL_ALUOP_MSB = 9;

    // All-zero word: a nop instruction whose rt field is 0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

endpackage : pipeline_pkg
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : Up-counter that sticks at all-ones instead of wrapping.
//               Cleared only by the asynchronous active-low reset.
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_inc,
    output logic [CNT_WIDTH-1:0] o_count
);

    localparam logic [CNT_WIDTH-1:0] C_MAX = {CNT_WIDTH{1'b1}};

    logic [CNT_WIDTH-1:0] r_count;

    // Increment on request, holding at the maximum value once reached
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_inc && (r_count != C_MAX)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;

endmodule : sat_counter
`default_nettype wire

// File: rtl/idex_pipeline_register.sv
`default_nettype none
// ============================================================================
// Module      : idex_pipeline_register
// Description : ID/EX pipeline register. Feeds the hazard unit (MemRead and
//               EX instruction), inserts load-use bubbles, applies branch
//               squashes (deferred while held) and counts bubbles.
// Revision    : 1.0 - initial release
// ============================================================================
module idex_pipeline_register #(
    parameter int DATA_WIDTH = 32,
    parameter int CTRL_WIDTH = pipeline_pkg::CTRL_WIDTH,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_hold,
    input  logic                  i_flush,
    input  logic                  i_write_enable_mux_control,
    input  logic [31:0]           i_id_instruction,
    input  logic [DATA_WIDTH-1:0] i_id_pc_plus4,
    input  logic [DATA_WIDTH-1:0] i_id_read_data1,
    input  logic [DATA_WIDTH-1:0] i_id_read_data2,
    input  logic [DATA_WIDTH-1:0] i_id_sign_ext_imm,
    input  logic [CTRL_WIDTH-1:0] i_id_control,
    output logic [31:0]           o_ex_instruction,
    output logic [DATA_WIDTH-1:0] o_ex_pc_plus4,
    output logic [DATA_WIDTH-1:0] o_ex_read_data1,
    output logic [DATA_WIDTH-1:0] o_ex_read_data2,
    output logic [DATA_WIDTH-1:0] o_ex_sign_ext_imm,
    output logic [CTRL_WIDTH-1:0] o_ex_control,
    output logic                  o_mem_read_from_idex,
    output logic                  o_ex_valid,
    output logic [CNT_WIDTH-1:0]  o_bubble_count
);

    import pipeline_pkg::*;

    logic [31:0]           r_ex_instruction;
    logic [DATA_WIDTH-1:0] r_ex_pc_plus4;
    logic [DATA_WIDTH-1:0] r_ex_read_data1;
    logic [DATA_WIDTH-1:0] r_ex_read_data2;
    logic [DATA_WIDTH-1:0] r_ex_sign_ext_imm;
    logic [CTRL_WIDTH-1:0] r_ex_control;
    logic                  r_ex_valid;
    logic                  r_flush_pending;

    logic                  w_squash;
    logic                  w_bubble;

    // A squash outranks a bubble; neither applies while the pipeline is held
    assign w_squash = !i_hold && (i_flush || r_flush_pending);
    assign w_bubble = !i_hold && !w_squash && !i_write_enable_mux_control;

    // Priority chain: hold, then squash, then bubble, then normal load
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ex_instruction  <= NOP_INSTR;
            r_ex_pc_plus4     <= '0;
            r_ex_read_data1   <= '0;
            r_ex_read_data2   <= '0;
            r_ex_sign_ext_imm <= '0;
            r_ex_control      <= '0;
            r_ex_valid        <= 1'b0;
            r_flush_pending   <= 1'b0;
        end else if (i_hold) begin
            // Freeze contents, but remember any flush so it is applied later
            if (i_flush) begin
                r_flush_pending <= 1'b1;
            end
        end else begin
            // Data fields always follow ID; they are don't-care when squashed
            r_ex_pc_plus4     <= i_id_pc_plus4;
            r_ex_read_data1   <= i_id_read_data1;
            r_ex_read_data2   <= i_id_read_data2;
            r_ex_sign_ext_imm <= i_id_sign_ext_imm;
            r_flush_pending   <= 1'b0;
            if (w_squash || w_bubble) begin
                // Zeroed control drops MemRead, releasing the load-use stall
                r_ex_instruction <= NOP_INSTR;
                r_ex_control     <= '0;
                r_ex_valid       <= 1'b0;
            end else begin
                r_ex_instruction <= i_id_instruction;
                r_ex_control     <= i_id_control;
                r_ex_valid       <= 1'b1;
            end
        end
    end

    sat_counter #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_bubble_counter (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_inc   (w_bubble),
        .o_count (o_bubble_count)
    );

    assign o_ex_instruction     = r_ex_instruction;
    assign o_ex_pc_plus4        = r_ex_pc_plus4;
    assign o_ex_read_data1      = r_ex_read_data1;
    assign o_ex_read_data2      = r_ex_read_data2;
    assign o_ex_sign_ext_imm    = r_ex_sign_ext_imm;
    assign o_ex_control         = r_ex_control;
    assign o_ex_valid           = r_ex_valid;
    assign o_mem_read_from_idex = r_ex_control[CTL_MEMREAD];

endmodule : idex_pipeline_register
`default_nettype wire

// File: tb/tb_idex_pipeline_register.sv
`default_nettype none
// ============================================================================
// Module      : tb_idex_pipeline_register
// Description : Directed self-checking bench for idex_pipeline_register.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_idex_pipeline_register;

    localparam int DW = 32;
    localparam int CW = 10;
    localparam int NW = 4;

    logic          clk;
    logic          rst_n;
    logic          hold;
    logic          flush;
    logic          wemc;
    logic [31:0]   id_instr;
    logic [DW-1:0] id_pc;
    logic [DW-1:0] id_rd1;
    logic [DW-1:0] id_rd2;
    logic [DW-1:0] id_imm;
    logic [CW-1:0] id_ctrl;
    logic [31:0]   ex_instr;
    logic [DW-1:0] ex_pc;
    logic [DW-1:0] ex_rd1;
    logic [DW-1:0] ex_rd2;
    logic [DW-1:0] ex_imm;
    logic [CW-1:0] ex_ctrl;
    logic          mem_read;
    logic          ex_valid;
    logic [NW-1:0] bcount;

    int checks = 0;
    int errors = 0;

    idex_pipeline_register #(
        .DATA_WIDTH (DW),
        .CTRL_WIDTH (CW),
        .CNT_WIDTH  (NW)
    ) dut (
        .i_clk                      (clk),
        .i_rst_n                    (rst_n),
        .i_hold                     (hold),
        .i_flush                    (flush),
        .i_write_enable_mux_control (wemc),
        .i_id_instruction           (id_instr),
        .i_id_pc_plus4              (id_pc),
        .i_id_read_data1            (id_rd1),
        .i_id_read_data2            (id_rd2),
        .i_id_sign_ext_imm          (id_imm),
        .i_id_control               (id_ctrl),
        .o_ex_instruction           (ex_instr),
        .o_ex_pc_plus4              (ex_pc),
        .o_ex_read_data1            (ex_rd1),
        .o_ex_read_data2            (ex_rd2),
        .o_ex_sign_ext_imm          (ex_imm),
        .o_ex_control               (ex_ctrl),
        .o_mem_read_from_idex       (mem_read),
        .o_ex_valid                 (ex_valid),
        .o_bubble_count             (bcount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One active edge, then return on the falling edge for sampling/driving
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic [31:0] instr, input logic [CW-1:0] ctrl, input logic [DW-1:0] base);
        id_instr = instr;
        id_ctrl  = ctrl;
        id_pc    = base + 32'd4;
        id_rd1   = base + 32'h11;
        id_rd2   = base + 32'h22;
        id_imm   = base + 32'h33;
    endtask

    initial begin
        rst_n = 1'b0;
        hold  = 1'b0;
        flush = 1'b0;
        wemc  = 1'b1;
        drive(32'hDEAD_BEEF, 10'h3FF, 32'h100);
        tick();
        tick();

        // Reset state
        check("rst_instr", ex_instr, 32'h0);
        check("rst_ctrl", {22'h0, ex_ctrl}, 32'h0);
        check("rst_pc", ex_pc, 32'h0);
        check("rst_memread", {31'h0, mem_read}, 32'h0);
        check("rst_valid", {31'h0, ex_valid}, 32'h0);
        check("rst_count", {28'h0, bcount}, 32'h0);
        rst_n = 1'b1;

        // Normal load of a lw (MEMREAD|REGWRITE|MEMTOREG|ALUSRC)
        drive(32'h8C22_0004, 10'h01B, 32'h1000);
        wemc = 1'b1;
        tick();
        check("load_instr", ex_instr, 32'h8C22_0004);
        check("load_ctrl", {22'h0, ex_ctrl}, 32'h01B);
        check("load_memread", {31'h0, mem_read}, 32'h1);
        check("load_valid", {31'h0, ex_valid}, 32'h1);
        check("load_pc", ex_pc, 32'h1004);
        check("load_rd1", ex_rd1, 32'h1011);
        check("load_rd2", ex_rd2, 32'h1022);
        check("load_imm", ex_imm, 32'h1033);

        // Load-use bubble
        drive(32'h0043_0820, 10'h061, 32'h2000);
        wemc = 1'b0;
        tick();
        check("bub_instr", ex_instr, 32'h0);
        check("bub_ctrl", {22'h0, ex_ctrl}, 32'h0);
        check("bub_memread", {31'h0, mem_read}, 32'h0);
        check("bub_valid", {31'h0, ex_valid}, 32'h0);
        check("bub_count", {28'h0, bcount}, 32'h1);
        wemc = 1'b1;
        tick();
        check("stalled_instr", ex_instr, 32'h0043_0820);
        check("stalled_ctrl", {22'h0, ex_ctrl}, 32'h061);
        check("stalled_valid", {31'h0, ex_valid}, 32'h1);
        check("stalled_count", {28'h0, bcount}, 32'h1);

        // Hold three cycles, flush pulsed in the second
        drive(32'h1111_2222, 10'h3C1, 32'h3000);
        hold = 1'b1;
        tick();
        check("hold1_instr", ex_instr, 32'h0043_0820);
        flush = 1'b1;
        wemc  = 1'b0;
        tick();
        check("hold2_instr", ex_instr, 32'h0043_0820);
        check("hold2_pc", ex_pc, 32'h2004);
        flush = 1'b0;
        tick();
        check("hold3_valid", {31'h0, ex_valid}, 32'h1);
        check("hold3_count", {28'h0, bcount}, 32'h1);
        hold = 1'b0;
        wemc = 1'b1;
        drive(32'h2222_3333, 10'h005, 32'h4000);
        tick();
        check("pend_instr", ex_instr, 32'h0);
        check("pend_ctrl", {22'h0, ex_ctrl}, 32'h0);
        check("pend_valid", {31'h0, ex_valid}, 32'h0);
        check("pend_count", {28'h0, bcount}, 32'h1);
        tick();
        check("after_pend_instr", ex_instr, 32'h2222_3333);
        check("after_pend_valid", {31'h0, ex_valid}, 32'h1);

        // Flush and bubble request together: squash, not counted
        drive(32'h8C44_0008, 10'h01B, 32'h5000);
        tick();
        flush = 1'b1;
        wemc  = 1'b0;
        drive(32'h3333_4444, 10'h001, 32'h6000);
        tick();
        check("fb_valid", {31'h0, ex_valid}, 32'h0);
        check("fb_memread", {31'h0, mem_read}, 32'h0);
        check("fb_count", {28'h0, bcount}, 32'h1);
        flush = 1'b0;
        wemc  = 1'b1;
        tick();
        check("fb_next_instr", ex_instr, 32'h3333_4444);

        // Asynchronous reset mid-hold discards pending flush
        hold  = 1'b1;
        flush = 1'b1;
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_instr", ex_instr, 32'h0);
        check("arst_valid", {31'h0, ex_valid}, 32'h0);
        check("arst_count", {28'h0, bcount}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        hold  = 1'b0;
        flush = 1'b0;
        drive(32'h4444_5555, 10'h002, 32'h7000);
        tick();
        check("post_rst_instr", ex_instr, 32'h4444_5555);
        check("post_rst_valid", {31'h0, ex_valid}, 32'h1);
        check("post_rst_memread", {31'h0, mem_read}, 32'h1);

        // Saturation of the 4-bit bubble counter
        wemc = 1'b0;
        for (int i = 0; i < 14; i++) tick();
        check("sat_14", {28'h0, bcount}, 32'hE);
        tick();
        check("sat_15", {28'h0, bcount}, 32'hF);
        tick();
        tick();
        check("sat_17", {28'h0, bcount}, 32'hF);
        wemc = 1'b1;
        tick();
        check("sat_hold", {28'h0, bcount}, 32'hF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_idex_pipeline_register
`default_nettype wire
